shift_rx_8: RTL and testbench
=============================

# shift_rx_8

Serial-to-parallel receiver for the team's 8-bit shift-register link. It samples one bit per `Shift_En` strobe from the upstream shift register's serial output and assembles framed 8-bit words, least-significant bit first. Each completed word is presented through a one-entry valid/ready output buffer to the consuming datapath. A sticky overrun flag records any word dropped because the buffer was still occupied.

## Interface
- `WIDTH`, default 8: word width in bits; the counter is `$clog2(WIDTH)` bits wide.
- `Clk` in 1: the only clock; everything samples on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Shift_In` in 1: serial data bit, valid when `Shift_En`=1.
- `Shift_En` in 1: bit strobe; one bit is accepted per cycle in which it is high.
- `Frame_Start` in 1: marks the current bit as bit 0 of a word; meaningful only when `Shift_En`=1.
- `Data_Ready` in 1: the consumer accepts `Data_Out` when this is high together with `Data_Valid`.
- `Clear_Overrun` in 1: synchronous clear of `Overrun`.
- `Data_Out` out WIDTH: buffered word, bit 0 = first bit received.
- `Data_Valid` out 1: `Data_Out` holds an unconsumed word.
- `Overrun` out 1: sticky; a completed word was dropped.
- `Busy` out 1: a partial word is in progress (state `RX_RECV`).

## Operation
- Two states:
  - `RX_IDLE`: no partial word held.
  - `RX_RECV`: 1 to WIDTH-1 bits collected.
- `RX_IDLE`:
  - `Shift_En`=1 with `Frame_Start`=1: load `Shift_In` into the MSB of the shift register, set count=1, go to `RX_RECV`.
  - `Shift_En`=1 with `Frame_Start`=0: ignore the bit and stay in `RX_IDLE`.
- `RX_RECV`, with `Shift_En`=1:
  - Shift right with `Shift_In` entering at the MSB, and increment count.
  - When count reaches WIDTH on this bit, the word is complete: apply the buffer rules below, set count=0, go to `RX_IDLE`.
- `RX_RECV`, `Frame_Start`=1 with `Shift_En`=1: discard the partial word and restart with this bit as bit 0 (count=1, stay in `RX_RECV`). No flag is raised.
- `Shift_En`=0: the shift register, count and state all hold, whatever `Frame_Start` is doing.
- Word completion, output buffer rules:
  - Buffer empty, or `Data_Valid`=1 with `Data_Ready`=1 on the same edge: load the word into `Data_Out` and keep/set `Data_Valid`=1.
  - `Data_Valid`=1 with `Data_Ready`=0: drop the word, leave `Data_Out` unchanged, set `Overrun`=1.
- Consume: on an edge with `Data_Valid`=1, `Data_Ready`=1 and no word completing, `Data_Valid` goes to 0. `Data_Out` keeps its last value.
- `Overrun`: set as above and cleared by `Clear_Overrun`. If set and clear happen on the same edge, set wins.
- WIDTH=1 is not supported; the minimum is 2.

## Timing
- Reset (asynchronous assertion, deassertion synchronous to `Clk` upstream): state=`RX_IDLE`, count=0, shift register=0, `Data_Out`=0, `Data_Valid`=0, `Overrun`=0, `Busy`=0.
- Reset mid-word discards the partial word. Reset while `Data_Valid`=1 discards the buffered word.
- Latency: the edge that samples the final bit also loads the buffer. `Data_Valid` is high in the following cycle.
- Back-to-back frames are allowed, with a new `Frame_Start` on the cycle right after the final bit. Minimum spacing is WIDTH strobe cycles per word.
- `Busy` is registered and equals (state == `RX_RECV`).
- `Data_Ready` may be held high permanently. In that case each word is visible for exactly one cycle, unless the next word completes on the consume edge.
- No combinational path from inputs to outputs.

## Structure
- Package `shift_pkg` holds:
  - `typedef enum logic {RX_IDLE, RX_RECV} rx_state_t`.
  - `localparam int SHIFT_WIDTH = 8`, used as the `WIDTH` default.
- One sub-module, `rx_out_buf`: the one-entry valid/ready holding register plus the overrun logic. Its ports are load strobe, data in, `Data_Ready`, `Clear_Overrun`, `Data_Out`, `Data_Valid`, `Overrun`.
- The top level keeps the shift register, the bit counter and the FSM.

## Test plan
- Reset, then frame 0xA5 (bits 1,0,1,0,0,1,0,1; `Frame_Start` on the first) with `Data_Ready`=0 → `Data_Out`=0xA5 and `Data_Valid`=1 one cycle after the 8th strobe. `Busy` is high for exactly the strobes 1 to 7 window.
- Strobes spaced by idle cycles (`Shift_En`=0 for 3 cycles between bits), word 0x3C → `Data_Out`=0x3C. Count holds during the gaps.
- Word 0x11 left unconsumed, then word 0x22 completes → `Data_Out` stays 0x11 and `Overrun`=1. `Clear_Overrun` pulsed on the same cycle as a new drop → `Overrun` remains 1.
- `Data_Ready` high on the same edge that 0x77 completes while 0x66 is buffered → `Data_Out`=0x77, `Data_Valid` stays 1, `Overrun`=0.
- `Frame_Start` reasserted after 5 bits, then 8 bits of 0xC3 → `Data_Out`=0xC3. Bits without `Frame_Start` in `RX_IDLE` are ignored.
- `Reset_n` pulled low mid-word (after 4 bits) and with `Data_Valid`=1 → all outputs 0 immediately, no clock edge needed. The next framed 0x5A is received correctly.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and sizing for the 8-bit shift-register link receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

  // Receiver FSM: no partial word held / 1..WIDTH-1 bits collected.
  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

  // Default word width of the link.
  localparam int SHIFT_WIDTH = 8;

endpackage

// File: rtl/rx_out_buf.sv
// One-entry valid/ready holding register for received words, plus sticky overrun flag.
// Latency: a word loaded on an edge is visible (Data_Valid=1) from that edge onwards.
// Backpressure: a load while full and not being consumed is dropped and sets Overrun.
//
// Ports:
//   Clk, Reset_n   - clock, asynchronous active-low reset
//   i_load, i_data - one-cycle strobe and the completed word
//   Data_Ready     - consumer accepts Data_Out when high together with Data_Valid
//   Clear_Overrun  - synchronous clear of Overrun (a same-edge set wins)
//   Data_Out, Data_Valid, Overrun - buffered word, occupancy, sticky drop flag
module rx_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             Data_Ready,
  input  logic             Clear_Overrun,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Data_Valid,
  output logic             Overrun
);

  logic [WIDTH-1:0] r_dat;
  logic             r_vld;
  logic             r_ovr;
  logic             w_accept;
  logic             w_drop;

  // A new word fits when the slot is empty or is being emptied on this edge.
  assign w_accept = i_load && (!r_vld || Data_Ready);
  assign w_drop   = i_load && r_vld && !Data_Ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_dat <= '0;
      r_vld <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dat <= i_data;
        r_vld <= 1'b1;
      end else if (r_vld && Data_Ready) begin
        r_vld <= 1'b0;
      end

      if (w_drop) begin
        r_ovr <= 1'b1;
      end else if (Clear_Overrun) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign Data_Out   = r_dat;
  assign Data_Valid = r_vld;
  assign Overrun    = r_ovr;

endmodule

// File: rtl/shift_rx_8.sv
// Serial-to-parallel receiver: assembles framed LSB-first words from strobed serial bits.
// Latency: the edge sampling the final bit loads the output buffer; Data_Valid high next cycle.
// Backpressure: one-entry buffer; a word completing while the buffer is full and not read is dropped (Overrun).
//
// Ports:
//   Clk, Reset_n           - clock, asynchronous active-low reset
//   Shift_In, Shift_En     - serial bit and its strobe
//   Frame_Start            - current strobed bit is bit 0 of a word (restarts any partial word)
//   Data_Ready, Clear_Overrun - consumer handshake and overrun clear
//   Data_Out, Data_Valid, Overrun, Busy - buffered word, occupancy, sticky drop flag, partial word in progress
module shift_rx_8
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Shift_In,
  input  logic             Shift_En,
  input  logic             Frame_Start,
  input  logic             Data_Ready,
  input  logic             Clear_Overrun,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Data_Valid,
  output logic             Overrun,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH);
  // Count value held just before the final bit arrives.
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic             w_load;

  // New bits enter at the MSB, so after WIDTH strobes the first bit sits at bit 0.
  assign w_shifted = {Shift_In, r_shreg[WIDTH-1:1]};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= RX_IDLE;
      r_count <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_shreg_nxt = r_shreg;
    w_load      = 1'b0;
    if (Shift_En) begin
      if (Frame_Start) begin
        // Start (or restart) a word; any partial word is silently discarded.
        // Older bits are shifted past before completion, so only the MSB matters.
        w_shreg_nxt = w_shifted;
        w_count_nxt = CW'(1);
        w_state_nxt = RX_RECV;
      end else if (r_state == RX_RECV) begin
        w_shreg_nxt = w_shifted;
        if (r_count == LAST_CNT) begin
          w_load      = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = RX_IDLE;
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end
    end
  end

  assign Busy = (r_state == RX_RECV);

  rx_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .i_load        (w_load),
    .i_data        (w_shifted),
    .Data_Ready    (Data_Ready),
    .Clear_Overrun (Clear_Overrun),
    .Data_Out      (Data_Out),
    .Data_Valid    (Data_Valid),
    .Overrun       (Overrun)
  );

endmodule

// File: tb/tb_shift_rx_8.sv
// Bench for shift_rx_8: vector table, directed corner sequences and random traffic vs a queue-based model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: Data_Ready driven by the stimulus (held low, pulsed, random, held high).
module tb_shift_rx_8;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Shift_In;
  logic         Shift_En;
  logic         Frame_Start;
  logic         Data_Ready;
  logic         Clear_Overrun;
  logic [W-1:0] Data_Out;
  logic         Data_Valid;
  logic         Overrun;
  logic         Busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: bits of the word in progress, in arrival order.
  logic         m_bits[$];
  logic [W-1:0] m_dout;
  logic         m_vld;
  logic         m_ovr;

  typedef struct {
    logic         se;
    logic         si;
    logic         fs;
    logic         rdy;
    logic         clr;
    logic [W-1:0] dout;
    logic         vld;
    logic         ovr;
    logic         busy;
  } vec_t;

  vec_t vt[12];

  shift_rx_8 #(.WIDTH(W)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Shift_In      (Shift_In),
    .Shift_En      (Shift_En),
    .Frame_Start   (Frame_Start),
    .Data_Ready    (Data_Ready),
    .Clear_Overrun (Clear_Overrun),
    .Data_Out      (Data_Out),
    .Data_Valid    (Data_Valid),
    .Overrun       (Overrun),
    .Busy          (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_dout = '0;
    m_vld  = 1'b0;
    m_ovr  = 1'b0;
  endtask

  // One rising edge of the link, described by its rules rather than its registers.
  task automatic model_edge(input logic se, input logic si, input logic fs,
                            input logic rdy, input logic clr);
    logic         done;
    logic         set_ovr;
    logic [W-1:0] word;
    done    = 1'b0;
    set_ovr = 1'b0;
    word    = '0;
    if (se) begin
      if (fs) begin
        m_bits.delete();
        m_bits.push_back(si);
      end else if (m_bits.size() > 0) begin
        m_bits.push_back(si);
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) word[i] = m_bits[i];
          m_bits.delete();
          done = 1'b1;
        end
      end
    end
    if (done) begin
      if (!m_vld || rdy) begin
        m_dout = word;
        m_vld  = 1'b1;
      end else begin
        set_ovr = 1'b1;
      end
    end else if (m_vld && rdy) begin
      m_vld = 1'b0;
    end
    if (set_ovr) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".dout"}, 32'(Data_Out), 32'(m_dout));
    check({tag, ".vld"},  32'(Data_Valid), 32'(m_vld));
    check({tag, ".ovr"},  32'(Overrun), 32'(m_ovr));
    check({tag, ".busy"}, 32'(Busy), 32'(m_bits.size() != 0));
  endtask

  task automatic step(input logic se, input logic si, input logic fs,
                      input logic rdy, input logic clr, input string tag);
    Shift_En      = se;
    Shift_In      = si;
    Frame_Start   = fs;
    Data_Ready    = rdy;
    Clear_Overrun = clr;
    @(posedge Clk);
    model_edge(se, si, fs, rdy, clr);
    #1;
    check_model(tag);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy_last,
                           input logic clr_last, input string tag);
    for (int i = 0; i < W; i++)
      step(1'b1, w[i], i == 0, (i == W-1) ? rdy_last : 1'b0,
           (i == W-1) ? clr_last : 1'b0, tag);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    Shift_En      = 1'b0;
    Shift_In      = 1'b0;
    Frame_Start   = 1'b0;
    Data_Ready    = 1'b0;
    Clear_Overrun = 1'b0;
    Reset_n       = 1'b0;
    #1;
    check("rst.dout", 32'(Data_Out), 32'h0);
    check("rst.vld",  32'(Data_Valid), 32'h0);
    check("rst.ovr",  32'(Overrun), 32'h0);
    check("rst.busy", 32'(Busy), 32'h0);
    model_reset();
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] a5;
    logic         rdy_r;
    a5      = 8'hA5;
    Reset_n = 1'b1;
    model_reset();
    #2;
    do_reset();

    // Vector table: stray bit in idle, frame 0xA5, hold, consume, Frame_Start without strobe.
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    for (int i = 1; i <= 8; i++)
      vt[i] = '{1'b1, a5[i-1], i == 1, 1'b0, 1'b0, (i == 8) ? a5 : 8'h00, i == 8, 1'b0, i < 8};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      step(vt[i].se, vt[i].si, vt[i].fs, vt[i].rdy, vt[i].clr, "vec");
      check($sformatf("vec%0d.dout", i), 32'(Data_Out), 32'(vt[i].dout));
      check($sformatf("vec%0d.vld", i),  32'(Data_Valid), 32'(vt[i].vld));
      check($sformatf("vec%0d.ovr", i),  32'(Overrun), 32'(vt[i].ovr));
      check($sformatf("vec%0d.busy", i), 32'(Busy), 32'(vt[i].busy));
    end

    // Strobes separated by 3 idle cycles; Frame_Start toggles during gaps and must be ignored.
    for (int i = 0; i < W; i++) begin
      step(1'b1, a5[0] ^ 1'b1 ^ 1'b1 ? 1'b0 : 1'b0, 1'b0, 1'b0, 1'b0, "dummy_never") ;
      break;
    end
    // The dummy step above is a plain idle-in-IDLE strobe without Frame_Start (ignored).
    begin
      logic [W-1:0] g;
      g = 8'h3C;
      for (int i = 0; i < W; i++) begin
        step(1'b1, g[i], i == 0, 1'b0, 1'b0, "gap");
        if (i < W-1)
          for (int k = 0; k < 3; k++) step(1'b0, 1'b1, k == 1, 1'b0, 1'b0, "gap_idle");
      end
    end
    check("gap.dout", 32'(Data_Out), 32'h3C);
    check("gap.vld",  32'(Data_Valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "consume");

    // Overrun: unconsumed 0x11 then 0x22 drops; clear; drop with same-edge clear.
    send_word(8'h11, 1'b0, 1'b0, "ovr_a");
    send_word(8'h22, 1'b0, 1'b0, "ovr_b");
    check("ovr.dout_kept", 32'(Data_Out), 32'h11);
    check("ovr.set",       32'(Overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ovr_clr");
    check("ovr.cleared", 32'(Overrun), 32'h0);
    send_word(8'h33, 1'b0, 1'b1, "ovr_c");
    check("ovr.set_wins", 32'(Overrun), 32'h1);
    check("ovr.dout_kept2", 32'(Data_Out), 32'h11);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "ovr_clr2");
    check("ovr.cleared2", 32'(Overrun), 32'h0);

    // Consume and load on the same edge.
    send_word(8'h66, 1'b0, 1'b0, "swap_a");
    send_word(8'h77, 1'b1, 1'b0, "swap_b");
    check("swap.dout", 32'(Data_Out), 32'h77);
    check("swap.vld",  32'(Data_Valid), 32'h1);
    check("swap.ovr",  32'(Overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "consume");

    // Restart after 5 bits, then 0xC3; then stray strobes in idle.
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), i == 0, 1'b0, 1'b0, "restart_pre");
    send_word(8'hC3, 1'b0, 1'b0, "restart");
    check("restart.dout", 32'(Data_Out), 32'hC3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "consume");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "stray");
    check("stray.busy", 32'(Busy), 32'h0);
    check("stray.vld",  32'(Data_Valid), 32'h0);

    // Reset mid-word with a buffered word, then a clean frame.
    send_word(8'h99, 1'b0, 1'b0, "prerst");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0, 1'b0, 1'b0, "prerst_part");
    check("prerst.busy", 32'(Busy), 32'h1);
    check("prerst.vld",  32'(Data_Valid), 32'h1);
    do_reset();
    send_word(8'h5A, 1'b0, 1'b0, "postrst");
    check("postrst.dout", 32'(Data_Out), 32'h5A);
    check("postrst.vld",  32'(Data_Valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "consume");

    // Random traffic: first half random Data_Ready, second half held high.
    for (int n = 0; n < 3000; n++) begin
      rdy_r = (n >= 1500) ? 1'b1 : 1'($urandom_range(0, 1));
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
           rdy_r, $urandom_range(0, 15) == 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
